// File: rtl/mux_source_arbiter.sv
// rtl/mux_source_arbiter.sv - two-channel round-robin source arbiter feeding a 2:1 data mux
// Optional strict priority for channel A: define ARB_STRICT_PRIORITY_EN.
module mux_source_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic [WIDTH-1:0] in_a,
  output logic [WIDTH-1:0] in_b,
  output logic             sel_a,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       a_full, b_full;
  logic [3:0] burst_cnt, burst_nxt;
  logic       last_grant_a, last_grant_nxt;

  logic       xfer, xfer_a, xfer_b;
  logic       a_load, b_load;
  logic       idle_pick_a;
  logic       a_hold, b_hold;
  logic [3:0] burst_inc;

  assign sel_a     = (state == GRANT_A);
  assign out_valid = (state != IDLE);

  assign xfer   = out_valid && out_ready;
  assign xfer_a = xfer && sel_a;
  assign xfer_b = xfer && !sel_a;

  assign a_ready = !a_full || xfer_a;
  assign b_ready = !b_full || xfer_b;
  assign a_load  = a_valid && a_ready;
  assign b_load  = b_valid && b_ready;

  // Saturating so a long uncontested run never wraps back into a switch point.
  assign burst_inc = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;

  // idle_pick_a: who wins when leaving IDLE; x_hold: granted channel keeps the mux after this xfer.
  always_comb begin
    idle_pick_a = 1'b0;
    a_hold      = 1'b0;
    b_hold      = 1'b0;
`ifdef ARB_STRICT_PRIORITY_EN
    idle_pick_a = a_full;
    a_hold      = a_load;
    b_hold      = b_load && !a_full;
`else
    idle_pick_a = a_full && (!b_full || !last_grant_a);
    a_hold      = a_load && !(b_full && (burst_cnt == BURST_LAST));
    b_hold      = b_load && !(a_full && (burst_cnt == BURST_LAST));
`endif
  end

  always_comb begin
    state_nxt      = state;
    burst_nxt      = burst_cnt;
    last_grant_nxt = last_grant_a;
    case (state)
      IDLE: begin
        if (idle_pick_a) begin
          state_nxt      = GRANT_A;
          burst_nxt      = 4'd0;
          last_grant_nxt = 1'b1;
        end else if (b_full) begin
          state_nxt      = GRANT_B;
          burst_nxt      = 4'd0;
          last_grant_nxt = 1'b0;
        end
      end
      GRANT_A: begin
        if (xfer) begin
          if (a_hold) begin
            burst_nxt = burst_inc;
          end else if (b_full) begin
            state_nxt      = GRANT_B;
            burst_nxt      = 4'd0;
            last_grant_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GRANT_B: begin
        if (xfer) begin
          if (b_hold) begin
            burst_nxt = burst_inc;
          end else if (a_full) begin
            state_nxt      = GRANT_A;
            burst_nxt      = 4'd0;
            last_grant_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      burst_cnt    <= 4'd0;
      last_grant_a <= 1'b0;
    end else begin
      state        <= state_nxt;
      burst_cnt    <= burst_nxt;
      last_grant_a <= last_grant_nxt;
    end
  end

  // A load in the same cycle as an xfer refills the register, so full stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_full <= 1'b0;
      in_a   <= '0;
    end else if (a_load) begin
      a_full <= 1'b1;
      in_a   <= a_data;
    end else if (xfer_a) begin
      a_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_full <= 1'b0;
      in_b   <= '0;
    end else if (b_load) begin
      b_full <= 1'b1;
      in_b   <= b_data;
    end else if (xfer_b) begin
      b_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_source_arbiter.sv
// tb/tb_mux_source_arbiter.sv - self-checking bench for mux_source_arbiter
module tb_mux_source_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid, out_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, sel_a, out_valid;
  logic [WIDTH-1:0] in_a, in_b;

  int checks   = 0;
  int failures = 0;

  mux_source_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .in_a(in_a), .in_b(in_b), .sel_a(sel_a),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       e_ar;
    logic       e_br;
    logic       e_ov;
    logic       e_sel;
    logic [7:0] e_ina;
    logic [7:0] e_inb;
  } vec_t;

  function automatic vec_t mk(logic av, logic [7:0] ad, logic bv, logic [7:0] bd, logic ordy,
                              logic e_ar, logic e_br, logic e_ov, logic e_sel,
                              logic [7:0] e_ina, logic [7:0] e_inb);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.e_ar = e_ar; v.e_br = e_br; v.e_ov = e_ov; v.e_sel = e_sel;
    v.e_ina = e_ina; v.e_inb = e_inb;
    return v;
  endfunction

  // Reference model: channel 0 = A, 1 = B; owner -1 means nobody holds the mux.
  int         m_owner;
  int         m_last;
  int         m_run;
  bit         m_full [2];
  logic [7:0] m_data [2];

  task automatic m_reset();
    m_owner = -1;
    m_last  = 1;
    m_run   = 0;
    for (int c = 0; c < 2; c++) begin
      m_full[c] = 1'b0;
      m_data[c] = 8'h00;
    end
  endtask

  function automatic bit m_ready(int c, bit ordy);
    return !m_full[c] || (m_owner == c && ordy);
  endfunction

  task automatic m_step(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd,
                        input bit ordy);
    bit         vld [2];
    logic [7:0] din [2];
    bit         ld  [2];
    bit         xfer;
    bit         forced_switch;
    int         nxt;
    int         own;
    int         oth;
    vld[0] = av; vld[1] = bv; din[0] = ad; din[1] = bd;
    xfer = (m_owner >= 0) && ordy;
    for (int c = 0; c < 2; c++) ld[c] = vld[c] && m_ready(c, ordy);
    nxt = m_owner;
    if (m_owner < 0) begin
      if (m_full[0] && m_full[1]) begin
`ifdef ARB_STRICT_PRIORITY_EN
        nxt = 0;
`else
        nxt = 1 - m_last;
`endif
      end else if (m_full[0]) nxt = 0;
      else if (m_full[1]) nxt = 1;
      if (nxt >= 0) begin
        m_run  = 0;
        m_last = nxt;
      end
    end else if (xfer) begin
      own = m_owner;
      oth = 1 - own;
`ifdef ARB_STRICT_PRIORITY_EN
      forced_switch = (own == 1) && m_full[0];
`else
      forced_switch = m_full[oth] && (m_run + 1 == MAX_BURST);
`endif
      if (ld[own] && !forced_switch) begin
        if (m_run < 15) m_run = m_run + 1;
      end else if (m_full[oth]) begin
        nxt    = oth;
        m_run  = 0;
        m_last = oth;
      end else begin
        nxt = -1;
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (ld[c]) begin
        m_full[c] = 1'b1;
        m_data[c] = din[c];
      end else if (xfer && m_owner == c) begin
        m_full[c] = 1'b0;
      end
    end
    m_owner = nxt;
  endtask

  task automatic drive_idle();
    a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  vec_t       vecs [13];
  logic [7:0] got [$];
  logic [7:0] exp_order [12];
  logic [7:0] a_cnt, b_cnt;
  logic       first_sel;
  bit         found;

  initial begin
    rst = 1;
    drive_idle();
    vecs[0]  = mk(1, 8'h3C, 0, 8'h00, 1,  1, 1, 0, 0, 8'h00, 8'h00);
    vecs[1]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 1, 0, 0, 8'h3C, 8'h00);
    vecs[2]  = mk(0, 8'h00, 0, 8'h00, 1,  1, 1, 1, 1, 8'h3C, 8'h00);
    vecs[3]  = mk(0, 8'h00, 0, 8'h00, 1,  1, 1, 0, 0, 8'h3C, 8'h00);
    vecs[4]  = mk(0, 8'h00, 1, 8'h55, 0,  1, 1, 0, 0, 8'h3C, 8'h00);
    vecs[5]  = mk(1, 8'h66, 0, 8'h00, 0,  1, 0, 0, 0, 8'h3C, 8'h55);
    vecs[6]  = mk(1, 8'h77, 0, 8'h00, 0,  0, 0, 1, 0, 8'h66, 8'h55);
    vecs[7]  = mk(1, 8'h77, 0, 8'h00, 0,  0, 0, 1, 0, 8'h66, 8'h55);
    vecs[8]  = mk(1, 8'h77, 0, 8'h00, 0,  0, 0, 1, 0, 8'h66, 8'h55);
    vecs[9]  = mk(1, 8'h77, 0, 8'h00, 1,  0, 1, 1, 0, 8'h66, 8'h55);
    vecs[10] = mk(0, 8'h00, 0, 8'h00, 0,  0, 1, 1, 1, 8'h66, 8'h55);
    vecs[11] = mk(0, 8'h00, 0, 8'h00, 1,  1, 1, 1, 1, 8'h66, 8'h55);
    vecs[12] = mk(0, 8'h00, 0, 8'h00, 0,  1, 1, 0, 0, 8'h66, 8'h55);
`ifdef ARB_STRICT_PRIORITY_EN
    for (int i = 0; i < 12; i++) exp_order[i] = 8'h10 + 8'(i);
`else
    for (int i = 0; i < 4; i++) begin
      exp_order[i]     = 8'h10 + 8'(i);
      exp_order[i + 4] = 8'h20 + 8'(i);
      exp_order[i + 8] = 8'h14 + 8'(i);
    end
`endif

    // Reset state held through five idle cycles
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("idle_a_ready", a_ready, 1);
      check("idle_b_ready", b_ready, 1);
      check("idle_out_valid", out_valid, 0);
      check("idle_sel_a", sel_a, 0);
      check("idle_in_a", in_a, 0);
      check("idle_in_b", in_b, 0);
    end

    // Single word, then B stall while A waits
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      a_valid = vecs[i].av; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_data = vecs[i].bd;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_a_ready", i), a_ready, vecs[i].e_ar);
      check($sformatf("vec%0d_b_ready", i), b_ready, vecs[i].e_br);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d_sel_a", i), sel_a, vecs[i].e_sel);
      check($sformatf("vec%0d_in_a", i), in_a, vecs[i].e_ina);
      check($sformatf("vec%0d_in_b", i), in_b, vecs[i].e_inb);
    end

    // Both channels streaming at full rate
    do_reset();
    a_cnt = 8'h10; b_cnt = 8'h20; first_sel = 1'b0;
    got.delete();
    for (int cyc = 0; cyc < 60 && got.size() < 12; cyc++) begin
      @(negedge clk);
      a_valid = 1; b_valid = 1; out_ready = 1;
      a_data = a_cnt; b_data = b_cnt;
      #1;
      if (out_valid) begin
        if (got.size() == 0) first_sel = sel_a;
        got.push_back(sel_a ? in_a : in_b);
      end
      if (a_ready) a_cnt = a_cnt + 8'd1;
      if (b_ready) b_cnt = b_cnt + 8'd1;
    end
    check("stream_count", got.size(), 12);
    check("stream_first_grant_a", first_sel, 1);
    for (int i = 0; i < 12 && i < got.size(); i++)
      check($sformatf("stream_word%0d", i), got[i], exp_order[i]);

    // Reset asserted while A holds the mux and both channels are full
    do_reset();
    found = 0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      a_valid = 1; b_valid = 1; out_ready = 1;
      a_data = 8'hC0 + 8'(cyc); b_data = 8'hD0 + 8'(cyc);
      #1;
      if (out_valid && sel_a && !b_ready) found = 1;
    end
    check("midburst_reached", found, 1);
    rst = 1;
    drive_idle();
    @(negedge clk);
    rst = 0;
    #1;
    check("midburst_out_valid", out_valid, 0);
    check("midburst_sel_a", sel_a, 0);
    check("midburst_a_ready", a_ready, 1);
    check("midburst_b_ready", b_ready, 1);
    check("midburst_in_a", in_a, 0);
    @(negedge clk);
    a_valid = 1; b_valid = 1; a_data = 8'hA1; b_data = 8'hB1;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1;
    check("post_reset_tie_valid", out_valid, 1);
    check("post_reset_tie_sel_a", sel_a, 1);
    check("post_reset_tie_in_a", in_a, 8'hA1);

    // Randomized traffic against the reference model
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      a_data    = 8'($urandom_range(0, 255));
      b_data    = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rand_a_ready", a_ready, m_ready(0, out_ready));
      check("rand_b_ready", b_ready, m_ready(1, out_ready));
      check("rand_out_valid", out_valid, m_owner >= 0);
      check("rand_sel_a", sel_a, m_owner == 0);
      check("rand_in_a", in_a, m_data[0]);
      check("rand_in_b", in_b, m_data[1]);
      @(posedge clk);
      if (rst) m_reset();
      else m_step(a_valid, a_data, b_valid, b_data, out_ready);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
